xgmii_rx_measure: RTL
=====================

# xgmii_rx_measure

Per-port XGMII receive analyser for the measurement datapath. It consumes one 64-bit XGMII receive stream, delineates frames and validates them, and extracts the IPv4 source address and an embedded 32-bit transmit timestamp. Each second it publishes packets-per-second, bytes-per-second and the one-way latency of the last good frame. One instance sits downstream of each receiving MAC and feeds the rxN_* status registers read over PCI.

## Interface
- CLK_HZ, 156250000: sys_clk frequency; sets the one-second window.
- MIN_LEN, 64: minimum good frame length in bytes (destination MAC through FCS).
- sys_clk  in  1  156.25 MHz XGMII/core clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- xgmii_rxd  in  64  receive data; lane k = bits [8k+7:8k].
- xgmii_rxc  in  8  receive control; bit k marks lane k as a control character.
- global_counter  in  32  free-running cycle counter shared with the transmit side.
- rx_pps  out  32  good frames in the last completed second.
- rx_throughput  out  32  good-frame bytes (dst MAC through FCS) in the last completed second.
- rx_latency  out  24  global_counter minus timestamp of the last good frame, saturated.
- rx_ipv4_ip  out  32  IPv4 source address of the last good frame.

## Operation
- Start: rxc[0]=1 and rxd[7:0]=FB. Only lane 0 is a legal start position. Word index w=0 is the start word and contributes 0 bytes.
- Frame byte b (0 = first destination MAC byte) is located at word (b+8)/8, lane (b+8)%8.
- Terminate: the first lane k with rxc[k]=1 and byte FD, at word w≥1. Frame length = 8·(w−1)+k.
- Error: any control lane holding FE, or any control byte other than FD inside the frame, sends the FSM to DROP.
- IP capture: at w=4, {lane2,lane3,lane4,lane5} is latched as candidate IP.
- Timestamp capture: at w=6, {lane2..lane5} is latched as candidate timestamp (frame bytes 42–45).
- FSM IDLE → RECV on start.
- RECV → IDLE on a good terminate.
- RECV → DROP on error.
- RECV → RECV (restart) on a new start; the aborted frame is discarded.
- DROP → IDLE on terminate or an all-idle word (rxc=FF, all lanes 07).
- DROP → RECV on start.
- Good frame: terminate in RECV, length ≥ MIN_LEN, and w ≥ 7 (timestamp captured). Otherwise the frame is discarded with no counter or output change.
- Length accumulates in 16 bits and saturates at FFFF.
- On a good frame:
  - pkt_acc += 1.
  - byte_acc += length.
  - rx_ipv4_ip ← candidate IP.
  - rx_latency ← (global_counter − ts) mod 2^32, taken from the terminate cycle; if the result exceeds FFFFFF, rx_latency ← FFFFFF.
- Second timer: a down-counter reloads CLK_HZ−1; tick when it reaches 0.
- On the tick cycle:
  - rx_pps ← pkt_acc plus that cycle's increment.
  - rx_throughput ← byte_acc plus that cycle's increment.
  - Both accumulators clear to 0.
- Accumulators saturate at FFFFFFFF.

## Timing
- Reset values:
  - all outputs 0.
  - FSM IDLE.
  - accumulators 0.
  - timer CLK_HZ−1.
- The first tick occurs CLK_HZ cycles after reset release.
- Inputs are sampled directly with no input register.
- rx_latency and rx_ipv4_ip change on the edge that samples the terminate word (visible the following cycle).
- rx_pps and rx_throughput change on the edge that samples the tick cycle.
- A good terminate and a tick in the same cycle: the frame counts in the window being published.
- Start immediately after terminate (back-to-back words) is accepted with no dead cycle.
- Asserting reset mid-frame clears everything immediately; after release, words preceding the next start are ignored.

## Structure
- Package measure_pkg holds:
  - XGMII characters: XG_START=FB, XG_TERM=FD, XG_ERR=FE, XG_IDLE=07.
  - Word/lane constants: IP_WORD=4, TS_WORD=6, TS_LANE_LO=2.
  - FSM state enum {IDLE, RECV, DROP}.
- Sub-module xgmii_term_find: combinational; takes rxd/rxc and returns term_hit, term_lane[2:0], err_hit (FE or illegal control). Used once per instance.

## Test plan
- 64-byte frame: start, 8 data words, FD in lane 0 of word 9; IP word lanes 2–5 = 0A,00,15,69; ts = global_counter−100 → rx_ipv4_ip=0A001569, rx_latency=100; at tick rx_pps=1, rx_throughput=64.
- 1000 back-to-back 72-byte frames within one window (FD at lane 0 of word 10) → rx_pps=1000, rx_throughput=72000; the next window with no traffic publishes 0/0.
- Errored and short frames: FE in lane 3 mid-frame, plus a 56-byte frame → both uncounted; rx_pps=0 and rx_ipv4_ip unchanged.
- Latency saturation: ts = global_counter − 0x0100_0000 → rx_latency=FFFFFF. Wrap case: ts=FFFFFFF0 with global_counter=10 → rx_latency=0x20.
- Terminate coinciding with the tick cycle → frame included in the published rx_pps; the new window starts at 0.
- Reset asserted at word 3 of a frame, released, then a clean 64-byte frame → only the clean frame is counted (rx_pps=1).

Source files
------------

// File: rtl/measure_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | measure_pkg                                                                |
// | Shared XGMII characters, frame word/lane positions and FSM state type.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package measure_pkg;

   localparam logic [7:0] XG_START = 8'hFB;
   localparam logic [7:0] XG_TERM  = 8'hFD;
   localparam logic [7:0] XG_ERR   = 8'hFE;
   localparam logic [7:0] XG_IDLE  = 8'h07;

   localparam logic [2:0] IP_WORD    = 3'd4;
   localparam logic [2:0] TS_WORD    = 3'd6;
   localparam int unsigned TS_LANE_LO = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } state_t;

   // Four consecutive lanes starting at lo, lowest lane in the MSBs (network order).
   function automatic logic [31:0] lane_word(input logic [63:0] rxd, input int unsigned lo);
      return {rxd[8*lo +: 8], rxd[8*(lo+1) +: 8], rxd[8*(lo+2) +: 8], rxd[8*(lo+3) +: 8]};
   endfunction

endpackage : measure_pkg
`default_nettype wire

// File: rtl/xgmii_term_find.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xgmii_term_find                                                            |
// | Locates the first terminate lane in a word and flags error/illegal control.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xgmii_term_find
   import measure_pkg::*;
(
   input  logic [63:0] rxd,
   input  logic [7:0]  rxc,
   output logic        term_hit,
   output logic [2:0]  term_lane,
   output logic        err_hit
);

   // Control lanes after the terminate are idle fill; only FE there is an error.
   always_comb begin
      term_hit  = 1'b0;
      term_lane = 3'd0;
      err_hit   = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rxc[k]) begin
            if (rxd[8*k +: 8] == XG_ERR) begin
               err_hit = 1'b1;
            end else if (rxd[8*k +: 8] == XG_TERM) begin
               if (!term_hit) begin
                  term_hit  = 1'b1;
                  term_lane = 3'(k);
               end
            end else if (!term_hit) begin
               err_hit = 1'b1;
            end
         end
      end
   end

endmodule : xgmii_term_find
`default_nettype wire

// File: rtl/xgmii_rx_measure.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xgmii_rx_measure                                                           |
// | XGMII RX frame validation with per-second pps/byte rates and latency.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xgmii_rx_measure
   import measure_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 156250000,
   parameter int unsigned MIN_LEN = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   input  logic [31:0] global_counter,
   output logic [31:0] rx_pps,
   output logic [31:0] rx_throughput,
   output logic [23:0] rx_latency,
   output logic [31:0] rx_ipv4_ip
);

   localparam logic [31:0] c_TIMER_RELOAD = 32'(CLK_HZ - 1);
   localparam logic [15:0] c_MIN_LEN      = 16'(MIN_LEN);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_word;
   logic [15:0] r_len;
   logic [31:0] r_ip_cand;
   logic [31:0] r_ts_cand;
   logic [31:0] r_timer;
   logic [31:0] r_pkt_acc;
   logic [31:0] r_byte_acc;

   logic        w_start;
   logic        w_all_idle;
   logic        w_term_hit;
   logic [2:0]  w_term_lane;
   logic        w_err_hit;
   logic        w_in_frame;
   logic        w_beat;
   logic        w_good;
   logic [16:0] w_len_sum;
   logic [15:0] w_frame_len;
   logic [31:0] w_lat_raw;
   logic        w_tick;
   logic [32:0] w_pkt_sum;
   logic [32:0] w_byte_sum;
   logic [31:0] w_pkt_next;
   logic [31:0] w_byte_next;

   xgmii_term_find u_term_find (
      .rxd       (xgmii_rxd),
      .rxc       (xgmii_rxc),
      .term_hit  (w_term_hit),
      .term_lane (w_term_lane),
      .err_hit   (w_err_hit)
   );

   assign w_start    = xgmii_rxc[0] && (xgmii_rxd[7:0] == XG_START);
   assign w_all_idle = (xgmii_rxc == 8'hFF) && (xgmii_rxd == {8{XG_IDLE}});

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_start) w_state_nxt = RECV;
         RECV: begin
            if (w_start)         w_state_nxt = RECV;
            else if (w_err_hit)  w_state_nxt = DROP;
            else if (w_term_hit) w_state_nxt = IDLE;
         end
         DROP: begin
            if (w_start)                       w_state_nxt = RECV;
            else if (w_term_hit || w_all_idle) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_len_sum   = {1'b0, r_len} + {14'd0, w_term_lane};
   assign w_frame_len = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

   // A restart word inside RECV takes priority over any terminate/error decode.
   always_comb begin
      w_in_frame = 1'b0;
      w_beat     = 1'b0;
      w_good     = 1'b0;
      if (r_state == RECV && !w_start) begin
         w_in_frame = 1'b1;
         w_beat     = !w_err_hit && !w_term_hit;
         w_good     = !w_err_hit && w_term_hit && (r_word == 3'd7) &&
                      (w_frame_len >= c_MIN_LEN);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_word    <= 3'd0;
         r_len     <= 16'd0;
         r_ip_cand <= 32'd0;
         r_ts_cand <= 32'd0;
      end else if (w_start) begin
         r_word <= 3'd1;
         r_len  <= 16'd0;
      end else if (w_in_frame) begin
         if (r_word == IP_WORD) r_ip_cand <= lane_word(xgmii_rxd, TS_LANE_LO);
         if (r_word == TS_WORD) r_ts_cand <= lane_word(xgmii_rxd, TS_LANE_LO);
         if (w_beat) begin
            if (r_word != 3'd7) r_word <= r_word + 3'd1;
            r_len <= (r_len > 16'hFFF7) ? 16'hFFFF : r_len + 16'd8;
         end
      end
   end

   assign w_lat_raw = global_counter - r_ts_cand;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_latency <= 24'd0;
         rx_ipv4_ip <= 32'd0;
      end else if (w_good) begin
         rx_latency <= (|w_lat_raw[31:24]) ? 24'hFFFFFF : w_lat_raw[23:0];
         rx_ipv4_ip <= r_ip_cand;
      end
   end

   assign w_tick      = (r_timer == 32'd0);
   assign w_pkt_sum   = {1'b0, r_pkt_acc} + {32'd0, w_good};
   assign w_byte_sum  = {1'b0, r_byte_acc} + {17'd0, (w_good ? w_frame_len : 16'd0)};
   assign w_pkt_next  = w_pkt_sum[32]  ? 32'hFFFFFFFF : w_pkt_sum[31:0];
   assign w_byte_next = w_byte_sum[32] ? 32'hFFFFFFFF : w_byte_sum[31:0];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_timer       <= c_TIMER_RELOAD;
         r_pkt_acc     <= 32'd0;
         r_byte_acc    <= 32'd0;
         rx_pps        <= 32'd0;
         rx_throughput <= 32'd0;
      end else if (w_tick) begin
         r_timer       <= c_TIMER_RELOAD;
         r_pkt_acc     <= 32'd0;
         r_byte_acc    <= 32'd0;
         rx_pps        <= w_pkt_next;
         rx_throughput <= w_byte_next;
      end else begin
         r_timer    <= r_timer - 32'd1;
         r_pkt_acc  <= w_pkt_next;
         r_byte_acc <= w_byte_next;
      end
   end

endmodule : xgmii_rx_measure
`default_nettype wire
